// File: rtl/ram_fifo_pkg.sv
// Shared helpers for the RAM-backed FIFO controller.
// cnt_width: bit width needed for an occupancy of 0..WORDS+2.
// next_ptr : RAM address increment with wrap at WORDS-1 (WORDS need not be a power of two).
package ram_fifo_pkg;

  // Occupancy of the 2-entry output buffer (0..2)
  typedef logic [1:0] bcnt_t;

  function automatic int unsigned cnt_width(input int unsigned words);
    return $clog2(words + 32'd3);
  endfunction

  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned words);
    return (ptr == words - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_out_buf2.sv
// Two-entry register buffer that holds words returned by the RAM read port.
// Ports: i_clk/i_rst clock and async active-high reset, i_clr synchronous clear,
//        i_push/i_data capture a word at the tail, i_pop drops the head,
//        o_head current head word, o_cnt number of words held (0..2).
// No flow control: the caller never pushes into a full buffer or pops an empty one.
module fifo_out_buf2
  import ram_fifo_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output bcnt_t         o_cnt
);

  logic [DW-1:0] r_ent0;
  logic [DW-1:0] r_ent1;
  bcnt_t         r_cnt;

  // Entry 0 is always the head; a pop shifts entry 1 down
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ent0 <= '0;
      r_ent1 <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_ent0 <= i_data;
          else               r_ent1 <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_ent0 <= r_ent1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_ent0 <= r_ent1;
            r_ent1 <= i_data;
          end else begin
            r_ent0 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head = r_ent0;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller sequencing an external simple dual-port RAM (registered read,
// one-cycle latency) with first-word-fall-through streams on both sides.
// Ports: clk/rst clock and async active-high reset, flush synchronous clear,
//        s_valid/s_ready/s_data write stream, m_valid/m_ready/m_data read stream,
//        count total words held, ram_addr_a/ram_wr_a/ram_din_a RAM write port,
//        ram_addr_b/ram_qout_b RAM read port.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter  int unsigned WORDS = 256,
  parameter  int unsigned DW    = 8,
  localparam int unsigned AW    = $clog2(WORDS),
  localparam int unsigned CW    = cnt_width(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [CW-1:0] count,
  output logic [AW-1:0] ram_addr_a,
  output logic          ram_wr_a,
  output logic [DW-1:0] ram_din_a,
  output logic [AW-1:0] ram_addr_b,
  input  logic [DW-1:0] ram_qout_b
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_ram_cnt;
  logic          r_inflight;

  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic          w_cap;
  bcnt_t         w_buf_cnt;

  assign s_ready = !rst && !flush && (r_ram_cnt != CW'(WORDS));
  assign w_push  = s_valid && s_ready;
  assign m_valid = (w_buf_cnt != 2'd0) && !flush;
  assign w_pop   = m_valid && m_ready;
  assign w_cap   = r_inflight && !flush;

  // Issue only when the buffer can absorb the word already in flight plus this one,
  // crediting the slot a pop frees this cycle
  assign w_issue = !flush && (r_ram_cnt != '0) &&
                   ((3'(w_buf_cnt) + 3'(r_inflight)) <= (3'd1 + 3'(w_pop)));

  assign ram_wr_a   = w_push;
  assign ram_addr_a = r_wr_ptr;
  assign ram_din_a  = s_data;
  assign ram_addr_b = r_rd_ptr;

  assign count = r_ram_cnt + CW'(r_inflight) + CW'(w_buf_cnt);

  // Pointers, RAM occupancy and the read-in-flight flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_push)  r_wr_ptr <= AW'(next_ptr(32'(r_wr_ptr), WORDS));
      if (w_issue) r_rd_ptr <= AW'(next_ptr(32'(r_rd_ptr), WORDS));
      r_inflight <= w_issue;
      r_ram_cnt  <= r_ram_cnt + CW'(w_push) - CW'(w_issue);
    end
  end

  fifo_out_buf2 #(
    .DW (DW)
  ) u_out_buf (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (flush),
    .i_push (w_cap),
    .i_data (ram_qout_b),
    .i_pop  (w_pop),
    .o_head (m_data),
    .o_cnt  (w_buf_cnt)
  );

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sequences an external simple dual-port RAM. The RAM has a registered read, one-cycle read latency, and both clocks tied to clk.
- Generates write and read addresses, tracks occupancy, and hides the RAM read latency behind a 2-entry output buffer.
- Presents first-word-fall-through valid/ready streams on both sides.
- Used wherever a deep buffered stream needs RAM storage rather than flops.

Parameters:
- WORDS, 256, RAM depth. Any value ≥ 2; power of two not required.
- DW, 8, data width.
- aw_t, logic [$clog2(WORDS)-1:0], RAM address type.
- dw_t, logic [DW-1:0], data type.
- cw_t, logic [$clog2(WORDS+3)-1:0], occupancy count type. Maximum occupancy is WORDS+2.

Ports:
- clk  in  1  single clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all contents.
- s_valid  in  1  write-side valid.
- s_ready  out  1  write-side ready.
- s_data  in  DW  write data.
- m_valid  out  1  read-side valid.
- m_ready  in  1  read-side ready.
- m_data  out  DW  read data (head of FIFO).
- count  out  cw_t  total words held (RAM + in-flight + buffer).
- ram_addr_a  out  aw_t  RAM write address.
- ram_wr_a  out  1  RAM write enable.
- ram_din_a  out  DW  RAM write data.
- ram_addr_b  out  aw_t  RAM read address.
- ram_qout_b  in  DW  RAM read data; valid one cycle after ram_addr_b is sampled.

Behaviour:
- Internal state:
  - wr_ptr, rd_ptr: aw_t.
  - ram_cnt: words written but not yet read-issued, 0..WORDS.
  - inflight: 1 bit, a read issued last edge.
  - out buffer: 2 entries, buf_cnt 0..2.
- Reset (async, while rst=1):
  - All state zero.
  - Outputs: s_ready=0, m_valid=0, ram_wr_a=0, count=0, ram_addr_a=0, ram_addr_b=0.
  - m_data is don't-care.
- push = s_valid && s_ready. s_ready = !rst && !flush && (ram_cnt != WORDS).
- On push:
  - ram_wr_a=1, ram_addr_a=wr_ptr, ram_din_a=s_data (combinational).
  - wr_ptr advances; WORDS-1 wraps to 0.
  - ram_wr_a=0 whenever push=0.
- pop = m_valid && m_ready. m_valid = (buf_cnt != 0) && !flush. m_data = buffer head.
- issue = !flush && (ram_cnt != 0) && (buf_cnt + inflight <= 1 + pop).
  - ram_addr_b = rd_ptr at all times.
  - On issue: rd_ptr advances with the same wrap rule as wr_ptr, and inflight<=1 next cycle, else inflight<=0.
- When inflight=1, ram_qout_b is captured into the buffer tail at that edge.
  - The pop-and-capture in the same cycle is legal.
  - The issue rule guarantees the buffer never overflows.
- ram_cnt next = ram_cnt + push - issue.
- count = ram_cnt + inflight + buf_cnt (combinational from registers).
- Latency:
  - A word pushed into an empty FIFO at edge t appears with m_valid=1 after edge t+2.
  - Sustained throughput is 1 word/cycle in and out.
- Full:
  - s_ready=0 when ram_cnt == WORDS.
  - A slot is freed at the read-issue edge, so a write into that address is legal from the following cycle.
  - A write and a read never hit the same unread address on the same edge.
- Empty: ram_cnt=0 gives no issue. m_valid stays 0 until the buffer fills.
- Simultaneous push and issue: ram_cnt unchanged.
- Simultaneous capture, pop and issue: buf_cnt unchanged. Steady state is buf_cnt=1, inflight=1.
- flush:
  - Takes priority over push, pop and issue.
  - Clears pointers, counts and buffer, and drops any in-flight read.
  - s_ready=0 and m_valid=0 during the flush cycle. Normal operation resumes the next cycle.
- Reset mid-operation: contents are lost, and state returns to reset values immediately.

Decomposition:
- Package ram_fifo_pkg:
  - Count-width helper function (clog2 of WORDS+3).
  - Pointer wrap function next_ptr(ptr, WORDS).
- Sub-module fifo_out_buf2:
  - 2-entry register buffer with push (capture), pop, head data and cnt.
  - No internal flow control; the controller guarantees no overflow.
- The top level holds the pointers, ram_cnt, inflight and issue logic.

Test Plan (WORDS=4, DW=8, RAM instance with both clocks tied to clk):
- Reset release, idle -> s_ready=1, m_valid=0, count=0. No ram_wr_a pulses.
- Single push 0x5A at edge t, m_ready=1 -> m_valid=1 and m_data=0x5A after edge t+2, m_valid=0 the next cycle, count returns to 0.
- Push 0x01..0x07 back-to-back with m_ready=0:
  - After 6 accepted words, count=6 (4 RAM + 2 buffer) and s_ready=0; 0x07 is held off.
  - Raise m_ready: outputs 0x01..0x07 in order, one per cycle after the initial buffer drain.
- Continuous push and pop at 1 word/cycle for 20 words (0x00..0x13) -> no bubbles after fill, in-order data, pointers wrap 3->0 correctly.
- With count=5, assert flush for 1 cycle together with s_valid=1 -> no write accepted, count=0 and m_valid=0 next cycle. A subsequent push 0xAA emerges alone.
- Assert rst asynchronously mid-stream with inflight=1 -> outputs reach reset values immediately, and no stale word appears after release.
